// File: rtl/rs_encoder_top.sv
// Interleaved CCSDS RS(255,223) encoder: data bytes pass through, then I*32 interleaved parity bytes.
// Optional macro RS_DUAL_BASIS_EN selects Berlekamp dual-basis symbols (LRPT mode).
module rs_encoder_top #(
    parameter int INTERLEAVE = 4,
    parameter int DATA_LEN   = 223,
    parameter int PARITY_LEN = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       new_cvcdu,
    input  logic       valid_in,
    input  logic [7:0] symbol_in,
    output logic       ready_out,
    output logic       valid_out,
    output logic [7:0] symbol_out,
    output logic       last_out,
    input  logic       ready_in
);
    localparam int DATA_BYTES = DATA_LEN * INTERLEAVE;
    localparam int PAR_BYTES  = PARITY_LEN * INTERLEAVE;
    localparam int CNT_W      = $clog2(DATA_BYTES + 1);
    localparam int CW_W       = (INTERLEAVE > 1) ? $clog2(INTERLEAVE) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_PAR  = CNT_W'(PAR_BYTES - 1);
    localparam logic [CW_W-1:0]  LAST_CW   = CW_W'(INTERLEAVE - 1);
    localparam logic [CW_W-1:0]  CW_AFTER_FIRST = CW_W'((INTERLEAVE > 1) ? 1 : 0);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h87 : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // g(x) = prod (x + alpha^(11j)), j = 112..143, built at elaboration
    function automatic logic [8*(PARITY_LEN+1)-1:0] gen_poly();
        logic [7:0] g [PARITY_LEN+1];
        logic [7:0] root;
        logic [8*(PARITY_LEN+1)-1:0] packed_g;
        for (int k = 0; k <= PARITY_LEN; k++) g[k] = (k == 0) ? 8'h01 : 8'h00;
        for (int j = 112; j < 112 + PARITY_LEN; j++) begin
            root = 8'h01;
            for (int e = 0; e < (11 * j) % 255; e++) root = xtime(root);
            for (int k = PARITY_LEN; k > 0; k--) g[k] = g[k-1] ^ gf_mul(g[k], root);
            g[0] = gf_mul(g[0], root);
        end
        for (int k = 0; k <= PARITY_LEN; k++) packed_g[8*k +: 8] = g[k];
        return packed_g;
    endfunction

    localparam logic [8*(PARITY_LEN+1)-1:0] GEN = gen_poly();

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CW_W-1:0]  cw_reg;
    logic [7:0]       par_reg [INTERLEAVE][PARITY_LEN];
    logic             valid_reg;
    logic [7:0]       sym_reg;
    logic             last_reg;

    logic       out_free;
    logic       accept;
    logic       restart;
    logic       advance_data;
    logic [7:0] enc_in;
    logic [7:0] fb;
    logic [7:0] par_top;
    logic [7:0] par_out;
    logic [7:0] upd_bank [PARITY_LEN];

    assign out_free     = !valid_reg || ready_in;
    assign ready_out    = (state_reg != ST_PARITY) && out_free;
    assign accept       = valid_in && ready_out;
    assign restart      = accept && new_cvcdu;
    assign advance_data = accept && !new_cvcdu && (state_reg == ST_DATA);
    assign par_top      = par_reg[cw_reg][PARITY_LEN-1];

`ifdef RS_DUAL_BASIS_EN
    // Row k of the conventional-to-dual matrix is packed at bits [8k+7:8k]
    localparam logic [63:0] TAL = 64'h8def_ec86_fa99_af7b;

    function automatic logic [7:0] to_dual(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int k = 0; k < 8; k++) if (x[k]) y ^= TAL[8*k +: 8];
        return y;
    endfunction

    function automatic logic [63:0] inv_cols();
        logic [63:0] cols;
        cols = '0;
        for (int b = 0; b < 8; b++)
            for (int x = 0; x < 256; x++)
                if (to_dual(8'(x)) == 8'(1 << b)) cols[8*b +: 8] = 8'(x);
        return cols;
    endfunction

    localparam logic [63:0] TAL_INV = inv_cols();

    function automatic logic [7:0] from_dual(input logic [7:0] y);
        logic [7:0] x;
        x = 8'h00;
        for (int b = 0; b < 8; b++) if (y[b]) x ^= TAL_INV[8*b +: 8];
        return x;
    endfunction

    assign enc_in  = from_dual(symbol_in);
    assign par_out = to_dual(par_top);
`else
    assign enc_in  = symbol_in;
    assign par_out = par_top;
`endif

    // A restarting byte sees an all-zero bank, so the feedback ignores the stale register
    assign fb = enc_in ^ (restart ? 8'h00 : par_top);

    generate
        for (genvar gi = 0; gi < PARITY_LEN; gi++) begin : g_tap
            localparam logic [7:0] G_K = GEN[8*gi +: 8];
            if (gi == 0) begin : g_first
                assign upd_bank[gi] = gf_mul(fb, G_K);
            end else begin : g_rest
                assign upd_bank[gi] = (restart ? 8'h00 : par_reg[cw_reg][gi-1]) ^ gf_mul(fb, G_K);
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            cw_reg    <= '0;
            valid_reg <= 1'b0;
            sym_reg   <= 8'h00;
            last_reg  <= 1'b0;
            for (int b = 0; b < INTERLEAVE; b++)
                for (int k = 0; k < PARITY_LEN; k++) par_reg[b][k] <= 8'h00;
        end else begin
            if (out_free) begin
                if (restart || advance_data) begin
                    valid_reg <= 1'b1;
                    sym_reg   <= symbol_in;
                    last_reg  <= 1'b0;
                end else if (state_reg == ST_PARITY) begin
                    valid_reg <= 1'b1;
                    sym_reg   <= par_out;
                    last_reg  <= (cnt_reg == LAST_PAR);
                end else begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end
            end

            if (restart) begin
                for (int b = 0; b < INTERLEAVE; b++)
                    for (int k = 0; k < PARITY_LEN; k++)
                        par_reg[b][k] <= (b == 0) ? upd_bank[k] : 8'h00;
                cnt_reg   <= CNT_W'(1);
                cw_reg    <= CW_AFTER_FIRST;
                state_reg <= ST_DATA;
            end else if (advance_data) begin
                for (int k = 0; k < PARITY_LEN; k++) par_reg[cw_reg][k] <= upd_bank[k];
                if (cnt_reg == LAST_DATA) begin
                    state_reg <= ST_PARITY;
                    cnt_reg   <= '0;
                    cw_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    cw_reg  <= (cw_reg == LAST_CW) ? '0 : cw_reg + CW_W'(1);
                end
            end else if (state_reg == ST_PARITY && out_free) begin
                for (int k = 0; k < PARITY_LEN; k++)
                    par_reg[cw_reg][k] <= (k == 0) ? 8'h00 : par_reg[cw_reg][k-1];
                if (cnt_reg == LAST_PAR) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    cw_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    cw_reg  <= (cw_reg == LAST_CW) ? '0 : cw_reg + CW_W'(1);
                end
            end
        end
    end

    assign valid_out  = valid_reg;
    assign symbol_out = sym_reg;
    assign last_out   = last_reg;

endmodule

// File: tb/tb_rs_encoder_top.sv
// Scoreboard bench for rs_encoder_top: long-division reference encoder plus syndrome checks on the captured stream.
`timescale 1ns/1ps
module tb_rs_encoder_top;
    localparam int I     = 4;
    localparam int K     = 223;
    localparam int P     = 32;
    localparam int NDATA = K * I;
    localparam int NTOT  = (K + P) * I;

    logic       clk_in    = 1'b0;
    logic       rst_in    = 1'b0;
    logic       new_cvcdu = 1'b0;
    logic       valid_in  = 1'b0;
    logic [7:0] symbol_in = 8'h00;
    logic       ready_in  = 1'b1;
    logic       ready_out;
    logic       valid_out;
    logic [7:0] symbol_out;
    logic       last_out;

    rs_encoder_top #(.INTERLEAVE(I), .DATA_LEN(K), .PARITY_LEN(P)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .new_cvcdu  (new_cvcdu),
        .valid_in   (valid_in),
        .symbol_in  (symbol_in),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .symbol_out (symbol_out),
        .last_out   (last_out),
        .ready_in   (ready_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [7:0] sym; logic last; } exp_t;
    exp_t       sb [$];
    logic [7:0] cap [$];
    int         total = 0;
    int         bad   = 0;
    bit         bp_en = 1'b0;
    int         ready_low_cnt = 0;

    int         gexp [0:509];
    int         glog [0:255];
    logic [7:0] gtab [0:P];
    logic [7:0] t_fwd [0:255];
    logic [7:0] t_inv [0:255];
    logic [7:0] frame_d [0:NDATA-1];
    logic [7:0] exp_f [0:NTOT-1];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(gexp[glog[a] + glog[b]]);
    endfunction

    task automatic build_tables();
        int x;
        logic [7:0] r;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x; gexp[i+255] = x; glog[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h187;
        end
        for (int k = 0; k <= P; k++) gtab[k] = (k == 0) ? 8'h01 : 8'h00;
        for (int j = 112; j < 112 + P; j++) begin
            r = 8'(gexp[(11 * j) % 255]);
            for (int k = P; k > 0; k--) gtab[k] = gtab[k-1] ^ gmul(gtab[k], r);
            gtab[0] = gmul(gtab[0], r);
        end
`ifdef RS_DUAL_BASIS_EN
        begin
            logic [7:0] tal [0:7];
            tal = '{8'h8d, 8'hef, 8'hec, 8'h86, 8'hfa, 8'h99, 8'haf, 8'h7b};
            for (int i = 0; i < 256; i++) begin
                logic [7:0] y;
                logic [7:0] iv;
                iv = 8'(i);
                y  = 8'h00;
                for (int k = 0; k < 8; k++) if (iv[k]) y ^= tal[7-k];
                t_fwd[i] = y;
                t_inv[y] = iv;
            end
        end
`else
        for (int i = 0; i < 256; i++) begin t_fwd[i] = 8'(i); t_inv[i] = 8'(i); end
`endif
    endtask

    // Reference: systematic encoding by polynomial long division of m(x)*x^32 by g(x)
    task automatic compute_expected();
        logic [7:0] pb [0:254];
        logic [7:0] coef;
        for (int c = 0; c < I; c++) begin
            for (int n = 0; n < 255; n++) pb[n] = (n < K) ? t_inv[frame_d[n*I+c]] : 8'h00;
            for (int i = 0; i < K; i++) begin
                coef = pb[i];
                if (coef != 8'h00)
                    for (int k = 0; k <= P; k++) pb[i+k] ^= gmul(coef, gtab[P-k]);
            end
            for (int m = 0; m < P; m++) exp_f[NDATA + m*I + c] = t_fwd[pb[K+m]];
        end
        for (int n = 0; n < NDATA; n++) exp_f[n] = frame_d[n];
    endtask

    task automatic push_expected(input int count);
        exp_t e;
        for (int n = 0; n < count; n++) begin
            e.sym  = exp_f[n];
            e.last = (n == NTOT - 1);
            sb.push_back(e);
        end
    endtask

    task automatic rand_frame();
        for (int n = 0; n < NDATA; n++) frame_d[n] = 8'($urandom);
    endtask

    always @(posedge clk_in) begin
        #1;
        ready_in = bp_en ? 1'($urandom & 1) : 1'b1;
    end

    // Output monitor: scoreboard pop on handshake, hold check during stalls
    bit         stall_prev = 1'b0;
    logic [7:0] held_sym;
    logic       held_last;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if (valid_out !== 1'b1 || symbol_out !== held_sym || last_out !== held_last) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b sym=%h last=%b, required v=1 sym=%h last=%b",
                             valid_out, symbol_out, last_out, held_sym, held_last);
                end
            end
            if (valid_out && ready_in) begin
                cap.push_back(symbol_out);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got sym=%h last=%b, required no output", symbol_out, last_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (symbol_out !== e.sym || last_out !== e.last) begin
                        bad++;
                        $display("FAIL out_byte[%0d]: got sym=%h last=%b, required sym=%h last=%b",
                                 cap.size() - 1, symbol_out, last_out, e.sym, e.last);
                    end
                end
            end
            stall_prev = valid_out && !ready_in;
            held_sym   = symbol_out;
            held_last  = last_out;
            if (!ready_out) ready_low_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic nc);
        bit acc;
        int guard;
        acc = 1'b0; guard = 0;
        valid_in = 1'b1; symbol_in = b; new_cvcdu = nc;
        while (!acc && guard < 5000) begin
            @(negedge clk_in); acc = ready_out;
            @(posedge clk_in); #1; guard++;
        end
        valid_in = 1'b0; new_cvcdu = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_byte: got no accept in %0d cycles, required ready_out=1", guard);
        end
    endtask

    task automatic send_frame(input int nbytes, input bit gaps);
        for (int n = 0; n < nbytes; n++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid_in = 1'b0;
                @(posedge clk_in); #1;
            end
            send_byte(frame_d[n], n == 0);
        end
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 20000) begin @(posedge clk_in); #1; guard++; end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d bytes still pending, required 0", tag, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    task automatic check_syndromes(input string tag, input int base);
        logic [7:0] cwd [0:254];
        logic [7:0] s;
        logic [7:0] beta;
        total++;
        if (cap.size() < base + NTOT) begin
            bad++;
            $display("FAIL %s_capture: got %0d bytes, required %0d", tag, cap.size(), base + NTOT);
            return;
        end
        for (int c = 0; c < I; c++) begin
            for (int n = 0; n < 255; n++) cwd[n] = t_inv[cap[base + n*I + c]];
            for (int j = 112; j < 112 + P; j++) begin
                beta = 8'(gexp[(11 * j) % 255]);
                s = 8'h00;
                for (int n = 0; n < 255; n++) s = gmul(s, beta) ^ cwd[n];
                total++;
                if (s !== 8'h00) begin
                    bad++;
                    $display("FAIL %s_syndrome cw=%0d j=%0d: got %h, required 00", tag, c, j, s);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        total += 4;
        if (ready_out !== 1'b1)    begin bad++; $display("FAIL reset_ready: got %b, required 1", ready_out); end
        if (valid_out !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %b, required 0", valid_out); end
        if (symbol_out !== 8'h00)  begin bad++; $display("FAIL reset_symbol: got %h, required 00", symbol_out); end
        if (last_out !== 1'b0)     begin bad++; $display("FAIL reset_last: got %b, required 0", last_out); end
        @(posedge clk_in); #3; rst_in = 1'b1;
        @(posedge clk_in); #1;
        for (int n = 0; n < 4; n++) begin
            send_byte(8'hA5 + 8'(n), 1'b0);
            total++;
            if (valid_out !== 1'b0) begin bad++; $display("FAIL idle_discard: got valid_out=%b, required 0", valid_out); end
        end
        $display("test_reset: reset values and idle discard checked");
    endtask

    task automatic test_zero_frame();
        for (int n = 0; n < NDATA; n++) frame_d[n] = 8'h00;
        compute_expected();
        cap.delete();
        ready_low_cnt = 0;
        push_expected(NTOT);
        send_frame(NDATA, 1'b0);
        wait_drain("zero");
        total += 2;
        if (ready_low_cnt != P * I) begin bad++; $display("FAIL zero_ready_low: got %0d cycles, required %0d", ready_low_cnt, P * I); end
        if (cap.size() != NTOT)      begin bad++; $display("FAIL zero_count: got %0d bytes, required %0d", cap.size(), NTOT); end
        $display("test_zero_frame: %0d bytes captured", cap.size());
    endtask

    task automatic test_impulse();
        logic [7:0] want;
        for (int n = 0; n < NDATA; n++) frame_d[n] = 8'h00;
        frame_d[NDATA - I] = t_fwd[1];   // last data byte of codeword 0
        compute_expected();
        cap.delete();
        push_expected(NTOT);
        send_frame(NDATA, 1'b0);
        wait_drain("impulse");
        total++;
        if (cap.size() != NTOT) begin
            bad++;
            $display("FAIL impulse_count: got %0d bytes, required %0d", cap.size(), NTOT);
        end else begin
            for (int m = 0; m < P; m++)
                for (int c = 0; c < I; c++) begin
                    want = (c == 0) ? t_fwd[gtab[P-1-m]] : 8'h00;
                    total++;
                    if (cap[NDATA + m*I + c] !== want) begin
                        bad++;
                        $display("FAIL impulse_parity m=%0d c=%0d: got %h, required %h", m, c, cap[NDATA + m*I + c], want);
                    end
                end
        end
        $display("test_impulse: parity checked against generator table");
    endtask

    task automatic test_random(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            rand_frame();
            compute_expected();
            cap.delete();
            push_expected(NTOT);
            send_frame(NDATA, 1'b0);
            wait_drain("random");
            check_syndromes("random", 0);
            $display("test_random: frame %0d captured %0d bytes", f, cap.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ref_out [0:NTOT-1];
        for (int f = 0; f < 2; f++) begin
            rand_frame();
            compute_expected();
            cap.delete();
            push_expected(NTOT);
            send_frame(NDATA, 1'b0);
            wait_drain("bp_ref");
            for (int n = 0; n < NTOT; n++) ref_out[n] = (n < cap.size()) ? cap[n] : 8'hxx;
            cap.delete();
            bp_en = 1'b1;
            push_expected(NTOT);
            send_frame(NDATA, 1'b1);
            wait_drain("bp");
            bp_en = 1'b0;
            total++;
            if (cap.size() != NTOT) begin
                bad++;
                $display("FAIL bp_count: got %0d bytes, required %0d", cap.size(), NTOT);
            end else begin
                for (int n = 0; n < NTOT; n++) begin
                    total++;
                    if (cap[n] !== ref_out[n]) begin
                        bad++;
                        $display("FAIL bp_vs_unstalled[%0d]: got %h, required %h", n, cap[n], ref_out[n]);
                    end
                end
            end
            $display("test_backpressure: frame %0d compared against unstalled run", f);
        end
    endtask

    task automatic test_abort();
        rand_frame();
        compute_expected();
        cap.delete();
        push_expected(500);
        send_frame(500, 1'b0);
        rand_frame();
        compute_expected();
        push_expected(NTOT);
        send_frame(NDATA, 1'b0);
        wait_drain("abort");
        check_syndromes("abort", 500);
        total++;
        if (cap.size() != 500 + NTOT) begin
            bad++;
            $display("FAIL abort_count: got %0d bytes, required %0d", cap.size(), 500 + NTOT);
        end
        $display("test_abort: %0d bytes captured", cap.size());
    endtask

    task automatic test_reset_mid_parity();
        int guard;
        rand_frame();
        compute_expected();
        cap.delete();
        push_expected(NTOT);
        send_frame(NDATA, 1'b0);
        guard = 0;
        while (cap.size() != NDATA + 59 && guard < 2000) begin @(posedge clk_in); #2; guard++; end
        total++;
        if (cap.size() != NDATA + 59) begin
            bad++;
            $display("FAIL midpar_reach: got %0d bytes, required %0d", cap.size(), NDATA + 59);
        end
        rst_in = 1'b0;
        #1;
        total += 4;
        if (ready_out !== 1'b1)   begin bad++; $display("FAIL midpar_ready: got %b, required 1", ready_out); end
        if (valid_out !== 1'b0)   begin bad++; $display("FAIL midpar_valid: got %b, required 0", valid_out); end
        if (symbol_out !== 8'h00) begin bad++; $display("FAIL midpar_symbol: got %h, required 00", symbol_out); end
        if (last_out !== 1'b0)    begin bad++; $display("FAIL midpar_last: got %b, required 0", last_out); end
        sb.delete();
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b1;
        @(posedge clk_in); #1;
        rand_frame();
        compute_expected();
        cap.delete();
        push_expected(NTOT);
        send_frame(NDATA, 1'b0);
        wait_drain("post_reset");
        check_syndromes("post_reset", 0);
        $display("test_reset_mid_parity: follow-up frame captured %0d bytes", cap.size());
    endtask

    initial begin
        build_tables();
        test_reset();
        test_zero_frame();
        test_impulse();
        test_random(20);
        test_backpressure();
        test_abort();
        test_reset_mid_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got time limit reached, required completion (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end

endmodule
